// File: rtl/mem_access_unit_if.sv
// CPU-bus / SRAM signal bundle for mem_access_unit.
// The slave modport is the unit itself; the master modport is whoever drives the CPU bus and models the SRAM.
interface mem_access_unit_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] Data_bus;
  logic              LD_MAR;
  logic              LD_MDR;
  logic              Rd_start;
  logic              Wr_start;
  logic [DATA_W-1:0] Mem_rdata;
  logic              Mem_ready;
  logic [DATA_W-1:0] MAR;
  logic [DATA_W-1:0] MDR;
  logic [DATA_W-1:0] Mem_addr;
  logic [DATA_W-1:0] Mem_wdata;
  logic              Mem_CE_n;
  logic              Mem_OE_n;
  logic              Mem_WE_n;
  logic              Busy;
  logic              Done;

  modport slave (
    input  Data_bus, LD_MAR, LD_MDR, Rd_start, Wr_start, Mem_rdata, Mem_ready,
    output MAR, MDR, Mem_addr, Mem_wdata, Mem_CE_n, Mem_OE_n, Mem_WE_n, Busy, Done
  );

  modport master (
    output Data_bus, LD_MAR, LD_MDR, Rd_start, Wr_start, Mem_rdata, Mem_ready,
    input  MAR, MDR, Mem_addr, Mem_wdata, Mem_CE_n, Mem_OE_n, Mem_WE_n, Busy, Done
  );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR latch plus timed SRAM read/write sequencer with a one-cycle Done pulse.
// Optional macro MEM_READY_HS_EN: completion additionally waits for Mem_ready.
module mem_access_unit #(
  parameter int DATA_W     = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_ok;

`ifdef MEM_READY_HS_EN
  assign ready_ok = bus.Mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.Mem_ready;
  assign ready_ok         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.LD_MAR) mar_d = bus.Data_bus;
        if (bus.LD_MDR) mdr_d = bus.Data_bus;
        // Read has priority; a simultaneous write request is dropped.
        if (bus.Rd_start) begin
          state_d = RD_WAIT;
          cnt_d   = 4'(READ_WAIT - 1);
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          we_n_d  = 1'b1;
        end else if (bus.Wr_start) begin
          state_d = WR_WAIT;
          cnt_d   = 4'(WRITE_WAIT - 1);
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b0;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (ready_ok) begin
            if (state_q == RD_WAIT) mdr_d = bus.Mem_rdata;
            state_d = IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
      end
    endcase

    // Busy spans the whole transaction including its Done cycle, so chained accesses keep it high.
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= '0;
      mdr_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.MAR       = mar_q;
  assign bus.MDR       = mdr_q;
  assign bus.Mem_addr  = mar_q;
  assign bus.Mem_wdata = mdr_q;
  assign bus.Mem_CE_n  = ce_n_q;
  assign bus.Mem_OE_n  = oe_n_q;
  assign bus.Mem_WE_n  = we_n_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: reset, read, write, conflicts, back-to-back, optional ready handshake.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_access_unit_if #(.DATA_W(16)) bus_if ();

  mem_access_unit #(.DATA_W(16), .READ_WAIT(2), .WRITE_WAIT(2)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus_if.MAR !== 16'h0000 || bus_if.MDR !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs MAR=%h MDR=%h required 0000 0000", bus_if.MAR, bus_if.MDR);
    end
    checks++;
    if ({bus_if.Mem_CE_n, bus_if.Mem_OE_n, bus_if.Mem_WE_n, bus_if.Busy, bus_if.Done} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_ctrl CE/OE/WE/Busy/Done=%b required 11100",
               {bus_if.Mem_CE_n, bus_if.Mem_OE_n, bus_if.Mem_WE_n, bus_if.Busy, bus_if.Done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int oe_low;
    oe_low = 0;
    bus_if.Data_bus = 16'h3000;
    bus_if.LD_MAR   = 1'b1;
    tick();
    bus_if.LD_MAR = 1'b0;
    checks++;
    if (bus_if.MAR !== 16'h3000 || bus_if.Mem_addr !== 16'h3000) begin
      errors++;
      $display("FAIL read_mar MAR=%h Mem_addr=%h required 3000", bus_if.MAR, bus_if.Mem_addr);
    end
    bus_if.Mem_rdata = 16'hBEEF;
    bus_if.Rd_start  = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      bus_if.Rd_start = 1'b0;
      if (bus_if.Mem_OE_n === 1'b0) oe_low++;
      if (e < 3) begin
        checks++;
        if (bus_if.MDR !== 16'h0000 || bus_if.Done !== 1'b0 || bus_if.Mem_CE_n !== 1'b0) begin
          errors++;
          $display("FAIL read_wait_e%0d MDR=%h Done=%b CE_n=%b required 0000 0 0",
                   e, bus_if.MDR, bus_if.Done, bus_if.Mem_CE_n);
        end
      end else if (e == 3) begin
        checks++;
        if (bus_if.MDR !== 16'hBEEF || bus_if.Done !== 1'b1 || bus_if.Mem_OE_n !== 1'b1) begin
          errors++;
          $display("FAIL read_capture MDR=%h Done=%b OE_n=%b required BEEF 1 1",
                   bus_if.MDR, bus_if.Done, bus_if.Mem_OE_n);
        end
      end else begin
        checks++;
        if (bus_if.Done !== 1'b0 || bus_if.Busy !== 1'b0) begin
          errors++;
          $display("FAIL read_after Done=%b Busy=%b required 0 0", bus_if.Done, bus_if.Busy);
        end
      end
    end
    checks++;
    if (oe_low != 2) begin
      errors++;
      $display("FAIL read_oe_width got %0d cycles required 2", oe_low);
    end
  endtask

  task automatic test_write();
    int we_low;
    int done_at;
    we_low  = 0;
    done_at = 0;
    bus_if.Data_bus = 16'h0042;
    bus_if.LD_MAR   = 1'b1;
    tick();
    bus_if.LD_MAR   = 1'b0;
    bus_if.Data_bus = 16'h1234;
    bus_if.LD_MDR   = 1'b1;
    tick();
    bus_if.LD_MDR   = 1'b0;
    bus_if.Wr_start = 1'b1;
    for (int e = 1; e <= 10 && done_at == 0; e++) begin
      tick();
      bus_if.Wr_start = 1'b0;
      if (bus_if.Mem_WE_n === 1'b0) begin
        we_low++;
        checks++;
        if (bus_if.Mem_addr !== 16'h0042 || bus_if.Mem_wdata !== 16'h1234 || bus_if.Mem_OE_n !== 1'b1) begin
          errors++;
          $display("FAIL write_stable addr=%h wdata=%h OE_n=%b required 0042 1234 1",
                   bus_if.Mem_addr, bus_if.Mem_wdata, bus_if.Mem_OE_n);
        end
      end
      if (bus_if.Done === 1'b1) done_at = e;
    end
    checks++;
    if (we_low != 2 || done_at != 3) begin
      errors++;
      $display("FAIL write_timing we_low=%0d done_edge=%0d required 2 3", we_low, done_at);
    end
    checks++;
    if (bus_if.MDR !== 16'h1234 || bus_if.Mem_WE_n !== 1'b1) begin
      errors++;
      $display("FAIL write_end MDR=%h WE_n=%b required 1234 1", bus_if.MDR, bus_if.Mem_WE_n);
    end
    tick();
  endtask

  task automatic test_conflict();
    int we_seen;
    int done_at;
    we_seen = 0;
    done_at = 0;
    bus_if.Mem_rdata = 16'h5A5A;
    bus_if.Rd_start  = 1'b1;
    bus_if.Wr_start  = 1'b1;
    tick();
    bus_if.Rd_start = 1'b0;
    bus_if.Wr_start = 1'b0;
    bus_if.Data_bus = 16'hFFFF;
    bus_if.LD_MDR   = 1'b1;
    bus_if.LD_MAR   = 1'b1;
    checks++;
    if (bus_if.Mem_OE_n !== 1'b0 || bus_if.Busy !== 1'b1) begin
      errors++;
      $display("FAIL conflict_read_started OE_n=%b Busy=%b required 0 1", bus_if.Mem_OE_n, bus_if.Busy);
    end
    for (int e = 2; e <= 10 && done_at == 0; e++) begin
      tick();
      bus_if.LD_MDR = 1'b0;
      bus_if.LD_MAR = 1'b0;
      if (bus_if.Mem_WE_n === 1'b0) we_seen++;
      if (bus_if.Done === 1'b1) done_at = e;
      else begin
        checks++;
        if (bus_if.MDR !== 16'h1234 || bus_if.MAR !== 16'h0042) begin
          errors++;
          $display("FAIL busy_hold MAR=%h MDR=%h required 0042 1234", bus_if.MAR, bus_if.MDR);
        end
      end
    end
    checks++;
    if (we_seen != 0 || done_at != 3 || bus_if.MDR !== 16'h5A5A || bus_if.MAR !== 16'h0042) begin
      errors++;
      $display("FAIL conflict_result we_low=%0d done_edge=%0d MDR=%h MAR=%h required 0 3 5A5A 0042",
               we_seen, done_at, bus_if.MDR, bus_if.MAR);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus_if.Mem_rdata = 16'h1111;
    bus_if.Rd_start  = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      bus_if.Rd_start = 1'b0;
      bus_if.Wr_start = (e == 3);
      checks++;
      if (bus_if.Busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy edge=%0d Busy=%b required 1", e, bus_if.Busy);
      end
      if (e == 3 || e == 6) begin
        checks++;
        if (bus_if.Done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done edge=%0d Done=%b required 1", e, bus_if.Done);
        end
      end
      if (e == 4) begin
        checks++;
        if (bus_if.Mem_WE_n !== 1'b0 || bus_if.Mem_OE_n !== 1'b1 || bus_if.Mem_wdata !== 16'h1111) begin
          errors++;
          $display("FAIL b2b_write_start WE_n=%b OE_n=%b wdata=%h required 0 1 1111",
                   bus_if.Mem_WE_n, bus_if.Mem_OE_n, bus_if.Mem_wdata);
        end
      end
    end
    tick();
    checks++;
    if (bus_if.Busy !== 1'b0 || bus_if.Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle Busy=%b Done=%b required 0 0", bus_if.Busy, bus_if.Done);
    end
  endtask

  task automatic test_reset_mid();
    bus_if.Mem_rdata = 16'h7777;
    bus_if.Rd_start  = 1'b1;
    tick();
    bus_if.Rd_start = 1'b0;
    checks++;
    if (bus_if.Mem_OE_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre OE_n=%b required 0", bus_if.Mem_OE_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.Mem_CE_n, bus_if.Mem_OE_n, bus_if.Mem_WE_n, bus_if.Busy} !== 4'b1110 ||
        bus_if.MAR !== 16'h0000 || bus_if.MDR !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid CE/OE/WE/Busy=%b MAR=%h MDR=%h required 1110 0000 0000",
               {bus_if.Mem_CE_n, bus_if.Mem_OE_n, bus_if.Mem_WE_n, bus_if.Busy}, bus_if.MAR, bus_if.MDR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef MEM_READY_HS_EN
  task automatic test_ready_hs();
    bus_if.Mem_ready = 1'b0;
    bus_if.Mem_rdata = 16'hCAFE;
    bus_if.Rd_start  = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      bus_if.Rd_start = 1'b0;
      checks++;
      if (bus_if.Mem_OE_n !== 1'b0 || bus_if.MDR !== 16'h0000 || bus_if.Done !== 1'b0) begin
        errors++;
        $display("FAIL hs_hold edge=%0d OE_n=%b MDR=%h Done=%b required 0 0000 0",
                 e, bus_if.Mem_OE_n, bus_if.MDR, bus_if.Done);
      end
    end
    bus_if.Mem_ready = 1'b1;
    tick();
    checks++;
    if (bus_if.MDR !== 16'hCAFE || bus_if.Done !== 1'b1 || bus_if.Mem_OE_n !== 1'b1) begin
      errors++;
      $display("FAIL hs_capture MDR=%h Done=%b OE_n=%b required CAFE 1 1",
               bus_if.MDR, bus_if.Done, bus_if.Mem_OE_n);
    end
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.Data_bus  = '0;
    bus_if.LD_MAR    = 1'b0;
    bus_if.LD_MDR    = 1'b0;
    bus_if.Rd_start  = 1'b0;
    bus_if.Wr_start  = 1'b0;
    bus_if.Mem_rdata = '0;
    bus_if.Mem_ready = 1'b1;

    test_reset();
    test_read();
    test_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_READY_HS_EN
    test_ready_hs();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
